// File: rtl/mult_share_arbiter_if.sv
// Requester-side bundle of the shared multiplier arbiter: per-requester
// request/lock/operands going in, grant/issue/result coming back.
interface mult_share_arbiter_if #(
    parameter int NREQ  = 3,
    parameter int LANES = 15,
    parameter int W     = 36
);
    logic [NREQ-1:0]                   req;
    logic [NREQ-1:0]                   lock;
    logic [NREQ-1:0][LANES-1:0][W-1:0] req_dataa;
    logic [NREQ-1:0][LANES-1:0][W-1:0] req_datab;
    logic [NREQ-1:0]                   grant;
    logic [NREQ-1:0]                   issue;
    logic [NREQ-1:0]                   res_valid;
    logic [LANES-1:0][W-1:0]           res_data;

    // Requester group drives requests and operands, observes grants and results.
    modport master (
        output req, lock, req_dataa, req_datab,
        input  grant, issue, res_valid, res_data
    );

    // Arbiter consumes requests and operands, produces grants and results.
    modport slave (
        input  req, lock, req_dataa, req_datab,
        output grant, issue, res_valid, res_data
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined LANES x W array multiplier among NREQ requesters.
// Round-robin ownership with optional lock for bursts, operand mux onto the
// multiplier, and a {valid,id} tag pipe matching the multiplier latency so
// every product is flagged back to the requester that issued it.
module mult_share_arbiter #(
    parameter int NREQ     = 3,
    parameter int LANES    = 15,
    parameter int W        = 36,
    parameter int MULT_LAT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    mult_share_arbiter_if.slave     bus,
    output logic [LANES-1:0][W-1:0] o_array_mult_dataa,
    output logic [LANES-1:0][W-1:0] o_array_mult_datab,
    input  logic [LANES-1:0][W-1:0] i_array_mult_result,
    output logic                    o_busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [IDW-1:0]    r_owner;
    logic [IDW-1:0]    w_ownerNext;
    logic [IDW-1:0]    r_rr;
    logic [IDW-1:0]    w_rrNext;
    logic [IDW-1:0]    w_ownerInc;
    logic [IDW:0]      w_idlePick;
    logic [IDW:0]      w_relPick;

    logic [NREQ-1:0]   w_grant;
    logic [NREQ-1:0]   w_issue;
    logic [NREQ-1:0]   w_others;
    logic [NREQ-1:0]   w_resValid;
    logic              w_issueAny;

    logic [MULT_LAT-1:0] r_tagValid;
    logic [IDW-1:0]      r_tagId [MULT_LAT];

    // First set bit of mask searching upward from start with wrap; returns {found, index}.
    function automatic logic [IDW:0] rrPick(input logic [NREQ-1:0] mask,
                                            input logic [IDW-1:0]  start);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NREQ;
            if (mask[IDW'(idx)]) begin
                res = {1'b1, IDW'(idx)};
            end
        end
        return res;
    endfunction

    // Owner state, owner id and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_rr    <= '0;
        end else begin
            r_state <= w_stateNext;
            r_owner <= w_ownerNext;
            r_rr    <= w_rrNext;
        end
    end

    // Ownership decisions: acquire from idle, hold under lock, release and hand over in one edge.
    always_comb begin
        w_stateNext = r_state;
        w_ownerNext = r_owner;
        w_rrNext    = r_rr;
        w_ownerInc  = (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
        w_idlePick  = rrPick(bus.req, r_rr);
        w_relPick   = rrPick(bus.req, w_ownerInc);
        case (r_state)
            ST_IDLE: begin
                if (w_idlePick[IDW]) begin
                    w_stateNext = ST_OWNED;
                    w_ownerNext = w_idlePick[IDW-1:0];
                end
            end
            ST_OWNED: begin
                if (!bus.lock[r_owner] &&
                    (!bus.req[r_owner] || (w_issueAny && (|w_others)))) begin
                    w_rrNext = w_ownerInc;
                    if (w_relPick[IDW]) begin
                        w_stateNext = ST_OWNED;
                        w_ownerNext = w_relPick[IDW-1:0];
                    end else begin
                        w_stateNext = ST_IDLE;
                        w_ownerNext = '0;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_ownerNext = '0;
            end
        endcase
    end

    // Grant decode, beat acceptance, operand mux and result-owner decode.
    always_comb begin
        w_grant = '0;
        if (r_state == ST_OWNED) begin
            w_grant[r_owner] = 1'b1;
        end
        w_issue    = w_grant & bus.req;
        w_issueAny = |w_issue;
        w_others   = bus.req & ~w_grant;
        o_array_mult_dataa = '0;
        o_array_mult_datab = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_issue[i]) begin
                o_array_mult_dataa = bus.req_dataa[i];
                o_array_mult_datab = bus.req_datab[i];
            end
        end
        w_resValid = '0;
        if (r_tagValid[MULT_LAT-1]) begin
            w_resValid[r_tagId[MULT_LAT-1]] = 1'b1;
        end
    end

    // Tag pipe tracks which requester owns each beat inside the multiplier.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_tagValid <= '0;
            for (int s = 0; s < MULT_LAT; s++) begin
                r_tagId[s] <= '0;
            end
        end else begin
            r_tagValid[0] <= w_issueAny;
            r_tagId[0]    <= r_owner;
            for (int s = 1; s < MULT_LAT; s++) begin
                r_tagValid[s] <= r_tagValid[s-1];
                r_tagId[s]    <= r_tagId[s-1];
            end
        end
    end

    assign bus.grant     = w_grant;
    assign bus.issue     = w_issue;
    assign bus.res_valid = w_resValid;
    assign bus.res_data  = i_array_mult_result;
    assign o_busy        = (r_state == ST_OWNED) | (|r_tagValid);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural 4-stage lane multiplier.
module tb_mult_share_arbiter;

    localparam int NREQ     = 3;
    localparam int LANES    = 15;
    localparam int W        = 36;
    localparam int MULT_LAT = 4;

    logic clk;
    logic rst;
    logic busy;
    logic [LANES-1:0][W-1:0] multA;
    logic [LANES-1:0][W-1:0] multB;
    logic [LANES-1:0][W-1:0] multRes;
    logic [LANES-1:0][W-1:0] multProd;
    logic [LANES-1:0][W-1:0] multPipe [MULT_LAT];

    int checks = 0;
    int errors = 0;

    mult_share_arbiter_if #(.NREQ(NREQ), .LANES(LANES), .W(W)) bus ();

    mult_share_arbiter #(
        .NREQ(NREQ), .LANES(LANES), .W(W), .MULT_LAT(MULT_LAT)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .bus                 (bus),
        .o_array_mult_dataa  (multA),
        .o_array_mult_datab  (multB),
        .i_array_mult_result (multRes),
        .o_busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared multiplier model: per-lane W-bit product, MULT_LAT register stages.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            multProd[l] = multA[l] * multB[l];
        end
    end

    always_ff @(posedge clk) begin
        multPipe[0] <= multProd;
        for (int s = 1; s < MULT_LAT; s++) begin
            multPipe[s] <= multPipe[s-1];
        end
    end

    assign multRes = multPipe[MULT_LAT-1];

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setOperands(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        for (int l = 0; l < LANES; l++) begin
            bus.req_dataa[r][l] = a;
            bus.req_datab[r][l] = b;
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] reqv, input logic [NREQ-1:0] lockv);
        bus.req  = reqv;
        bus.lock = lockv;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [NREQ-1:0] eGrant, input logic [NREQ-1:0] eIssue,
                               input logic [W-1:0] eA, input logic [W-1:0] eB,
                               input logic [NREQ-1:0] eRv, input logic [W-1:0] eRd);
        checkVal({tag, " grant"}, 64'(bus.grant), 64'(eGrant));
        checkVal({tag, " issue"}, 64'(bus.issue), 64'(eIssue));
        checkVal({tag, " multA0"}, 64'(multA[0]), 64'(eA));
        checkVal({tag, " multAhi"}, 64'(multA[LANES-1]), 64'(eA));
        checkVal({tag, " multB0"}, 64'(multB[0]), 64'(eB));
        checkVal({tag, " res_valid"}, 64'(bus.res_valid), 64'(eRv));
        if (eRv != '0) begin
            checkVal({tag, " res_data0"}, 64'(bus.res_data[0]), 64'(eRd));
            checkVal({tag, " res_datahi"}, 64'(bus.res_data[LANES-1]), 64'(eRd));
        end
    endtask

    task automatic step(input string tag,
                        input logic [NREQ-1:0] reqv, input logic [NREQ-1:0] lockv,
                        input logic [NREQ-1:0] eGrant, input logic [NREQ-1:0] eIssue,
                        input logic [W-1:0] eA, input logic [W-1:0] eB,
                        input logic [NREQ-1:0] eRv, input logic [W-1:0] eRd);
        applyStimulus(reqv, lockv);
        #1;
        checkOutput(tag, eGrant, eIssue, eA, eB, eRv, eRd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.lock = '0;
        bus.req_dataa = '0;
        bus.req_datab = '0;
        #2 rst = 1'b0;
        #1;
        checkOutput("rst", 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        checkVal("rst busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single requester burst of three beats
        setOperands(0, 36'd2, 36'd3);
        step("A0", 3'b001, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("A1", 3'b001, 3'b000, 3'b001, 3'b001, 36'd2, 36'd3, 3'b000, 36'd0);
        setOperands(0, 36'd5, 36'd7);
        step("A2", 3'b001, 3'b000, 3'b001, 3'b001, 36'd5, 36'd7, 3'b000, 36'd0);
        setOperands(0, 36'hF_FFFF_FFFF, 36'd4);
        step("A3", 3'b001, 3'b000, 3'b001, 3'b001, 36'hF_FFFF_FFFF, 36'd4, 3'b000, 36'd0);
        step("A4", 3'b000, 3'b000, 3'b001, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("A5", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b001, 36'd6);
        step("A6", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b001, 36'd35);
        step("A7", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b001, 36'hF_FFFF_FFFC);
        step("A8", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        checkVal("A busy", 64'(busy), 64'd0);

        // Round-robin rotation with all requesters pending (pointer now at 1)
        setOperands(0, 36'd3, 36'd3);
        setOperands(1, 36'd4, 36'd5);
        setOperands(2, 36'd6, 36'd7);
        step("B0", 3'b111, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("B1", 3'b111, 3'b000, 3'b010, 3'b010, 36'd4, 36'd5, 3'b000, 36'd0);
        step("B2", 3'b111, 3'b000, 3'b100, 3'b100, 36'd6, 36'd7, 3'b000, 36'd0);
        step("B3", 3'b111, 3'b000, 3'b001, 3'b001, 36'd3, 36'd3, 3'b000, 36'd0);
        step("B4", 3'b111, 3'b000, 3'b010, 3'b010, 36'd4, 36'd5, 3'b000, 36'd0);
        step("B5", 3'b111, 3'b000, 3'b100, 3'b100, 36'd6, 36'd7, 3'b010, 36'd20);
        step("B6", 3'b111, 3'b000, 3'b001, 3'b001, 36'd3, 36'd3, 3'b100, 36'd42);
        step("B7", 3'b000, 3'b000, 3'b010, 3'b000, 36'd0, 36'd0, 3'b001, 36'd9);
        step("B8", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b010, 36'd20);
        step("B9", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b100, 36'd42);
        step("B10", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b001, 36'd9);
        step("B11", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);

        // Requester 1 locks a five-beat burst while 0 and 2 wait (pointer at 2)
        step("C0", 3'b010, 3'b010, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("C1", 3'b111, 3'b010, 3'b010, 3'b010, 36'd4, 36'd5, 3'b000, 36'd0);
        step("C2", 3'b111, 3'b010, 3'b010, 3'b010, 36'd4, 36'd5, 3'b000, 36'd0);
        step("C3", 3'b111, 3'b010, 3'b010, 3'b010, 36'd4, 36'd5, 3'b000, 36'd0);
        step("C4", 3'b111, 3'b010, 3'b010, 3'b010, 36'd4, 36'd5, 3'b000, 36'd0);
        step("C5", 3'b111, 3'b010, 3'b010, 3'b010, 36'd4, 36'd5, 3'b010, 36'd20);
        step("C6", 3'b101, 3'b000, 3'b010, 3'b000, 36'd0, 36'd0, 3'b010, 36'd20);
        step("C7", 3'b101, 3'b000, 3'b100, 3'b100, 36'd6, 36'd7, 3'b010, 36'd20);
        step("C8", 3'b001, 3'b000, 3'b001, 3'b001, 36'd3, 36'd3, 3'b010, 36'd20);
        step("C9", 3'b000, 3'b000, 3'b001, 3'b000, 36'd0, 36'd0, 3'b010, 36'd20);
        step("C10", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("C11", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b100, 36'd42);
        step("C12", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b001, 36'd9);
        step("C13", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);

        // Locked owner 2 with a request bubble while others wait (pointer at 1)
        step("D0", 3'b100, 3'b100, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("D1", 3'b100, 3'b100, 3'b100, 3'b100, 36'd6, 36'd7, 3'b000, 36'd0);
        step("D2", 3'b011, 3'b100, 3'b100, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("D3", 3'b100, 3'b100, 3'b100, 3'b100, 36'd6, 36'd7, 3'b000, 36'd0);
        step("D4", 3'b000, 3'b000, 3'b100, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("D5", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b100, 36'd42);
        step("D6", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("D7", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b100, 36'd42);
        step("D8", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);

        // Asynchronous reset with beats in flight (pointer at 0)
        step("E0", 3'b111, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("E1", 3'b111, 3'b000, 3'b001, 3'b001, 36'd3, 36'd3, 3'b000, 36'd0);
        step("E2", 3'b111, 3'b000, 3'b010, 3'b010, 36'd4, 36'd5, 3'b000, 36'd0);
        step("E3", 3'b111, 3'b000, 3'b100, 3'b100, 36'd6, 36'd7, 3'b000, 36'd0);
        step("E4", 3'b111, 3'b000, 3'b001, 3'b001, 36'd3, 36'd3, 3'b000, 36'd0);
        applyStimulus(3'b111, 3'b000);
        #1;
        checkOutput("E5", 3'b010, 3'b010, 36'd4, 36'd5, 3'b001, 36'd9);
        checkVal("E5 busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("E5rst", 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        checkVal("E5rst busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(3'b111, 3'b000);
        #1;
        checkOutput("F0", 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        @(posedge clk);
        #1;
        step("F1", 3'b111, 3'b000, 3'b001, 3'b001, 36'd3, 36'd3, 3'b000, 36'd0);
        step("F2", 3'b000, 3'b000, 3'b010, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("F3", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("F4", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
        step("F5", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b001, 36'd9);
        step("F6", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);

        // Idle: nothing requested, multiplier inputs parked at zero
        for (int i = 0; i < MULT_LAT; i++) begin
            step("G", 3'b000, 3'b000, 3'b000, 3'b000, 36'd0, 36'd0, 3'b000, 36'd0);
            checkVal("G busy", 64'(busy), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
